// File: rtl/ramdp_pkg.sv
// rtl/ramdp_pkg.sv - shared state and requester encodings for the dual-port RAM arbiter
package ramdp_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

endpackage

// File: rtl/ramdp.sv
// rtl/ramdp.sv - dual-port RAM: synchronous write on port 0, combinational reads on both ports
module ramdp #(
   parameter int AddrSize = 4,
   parameter int DataSize = 8
) (
   input  logic                clock,
   input  logic                we,
   input  logic [AddrSize-1:0] addr0,
   input  logic [AddrSize-1:0] addr1,
   input  logic [DataSize-1:0] data_i0,
   output logic [DataSize-1:0] data_o0,
   output logic [DataSize-1:0] data_o1
);

   logic [DataSize-1:0] mem [2**AddrSize];

   always_ff @(posedge clock) begin
      if (we) mem[addr0] <= data_i0;
   end

   assign data_o0 = mem[addr0];
   assign data_o1 = mem[addr1];

endmodule

// File: rtl/ramdp_arbiter.sv
// rtl/ramdp_arbiter.sv - two-requester arbiter over one ramdp, with a clear-on-reset sweep
module ramdp_arbiter
   import ramdp_pkg::*;
#(
   parameter int AddrSize = 4,
   parameter int DataSize = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                a_req,
   input  logic                a_we,
   input  logic [AddrSize-1:0] a_addr,
   input  logic [DataSize-1:0] a_data_i,
   output logic                a_ack,
   output logic [DataSize-1:0] a_data_o,
   output logic                a_valid,
   input  logic                b_req,
   input  logic                b_we,
   input  logic [AddrSize-1:0] b_addr,
   input  logic [DataSize-1:0] b_data_i,
   output logic                b_ack,
   output logic [DataSize-1:0] b_data_o,
   output logic                b_valid,
   output logic                busy
);

   localparam logic [AddrSize-1:0] LastAddr = '1;

   state_t              state, state_nxt;
   req_id_t             last, last_nxt;
   logic [AddrSize-1:0] counter;
   logic                grant_a, grant_b, p0_is_a;
   logic                ram_we;
   logic [AddrSize-1:0] ram_addr0, ram_addr1;
   logic [DataSize-1:0] ram_wdata, ram_rdata0, ram_rdata1;
   logic [DataSize-1:0] a_rdata, b_rdata;
   logic                a_rd, b_rd;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= CLEAR;
         last  <= REQ_B;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   // Grants are gated by reset so nothing is acked while reset is held low.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      p0_is_a   = 1'b1;
      busy      = 1'b1;
      case (state)
         CLEAR: begin
            if (counter == LastAddr) state_nxt = RUN;
         end
         RUN: begin
            busy = !reset;
            if (reset) begin
               if (a_req && b_req && (a_we || b_we)) begin
                  if (last == REQ_B) begin
                     grant_a  = 1'b1;
                     last_nxt = REQ_A;
                  end else begin
                     grant_b  = 1'b1;
                     p0_is_a  = 1'b0;
                     last_nxt = REQ_B;
                  end
               end else if (a_req && b_req) begin
                  grant_a = 1'b1;
                  grant_b = 1'b1;
                  p0_is_a = (last == REQ_B);
               end else if (a_req) begin
                  grant_a  = 1'b1;
                  last_nxt = REQ_A;
               end else if (b_req) begin
                  grant_b  = 1'b1;
                  p0_is_a  = 1'b0;
                  last_nxt = REQ_B;
               end
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   assign a_ack = grant_a;
   assign b_ack = grant_b;

   always_ff @(posedge clock) begin
      if (!reset || state == RUN) counter <= '0;
      else                        counter <= counter + 1'b1;
   end

   // Port 0 carries the clear sweep, the sole writer, or the non-last reader.
   always_comb begin
      ram_addr0 = p0_is_a ? a_addr : b_addr;
      ram_addr1 = p0_is_a ? b_addr : a_addr;
      ram_wdata = p0_is_a ? a_data_i : b_data_i;
      ram_we    = p0_is_a ? (grant_a && a_we) : (grant_b && b_we);
      if (state == CLEAR) begin
         ram_addr0 = counter;
         ram_wdata = '0;
         ram_we    = reset;
      end
   end

   ramdp #(
      .AddrSize (AddrSize),
      .DataSize (DataSize)
   ) ramdp (
      .clock   (clock),
      .we      (ram_we),
      .addr0   (ram_addr0),
      .addr1   (ram_addr1),
      .data_i0 (ram_wdata),
      .data_o0 (ram_rdata0),
      .data_o1 (ram_rdata1)
   );

   assign a_rd    = grant_a && !a_we;
   assign b_rd    = grant_b && !b_we;
   assign a_rdata = p0_is_a ? ram_rdata0 : ram_rdata1;
   assign b_rdata = p0_is_a ? ram_rdata1 : ram_rdata0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         a_valid  <= 1'b0;
         b_valid  <= 1'b0;
         a_data_o <= '0;
         b_data_o <= '0;
      end else begin
         a_valid <= a_rd;
         b_valid <= b_rd;
         if (a_rd) a_data_o <= a_rdata;
         if (b_rd) b_data_o <= b_rdata;
      end
   end

endmodule

// File: tb/tb_ramdp_arbiter.sv
// tb/tb_ramdp_arbiter.sv - directed and randomized checks of ramdp_arbiter against a reference model
module tb_ramdp_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic       a_req, a_we, b_req, b_we;
   logic [3:0] a_addr, b_addr;
   logic [7:0] a_data_i, b_data_i;
   logic       a_ack, b_ack, a_valid, b_valid, busy;
   logic [7:0] a_data_o, b_data_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: memory image, remaining clear cycles, who won last, registered read results.
   bit [7:0] m_mem [16];
   int       m_clear_left = 16;
   bit       m_last_b = 1'b1;
   bit       m_av, m_bv;
   bit [7:0] m_ad, m_bd;

   bit       ga, gb, bb;
   bit [5:0] pat;
   bit [7:0] final_d;

   always #5 clock = ~clock;

   ramdp_arbiter #(.AddrSize(4), .DataSize(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .a_req    (a_req),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_data_i (a_data_i),
      .a_ack    (a_ack),
      .a_data_o (a_data_o),
      .a_valid  (a_valid),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_data_i (b_data_i),
      .b_ack    (b_ack),
      .b_data_o (b_data_o),
      .b_valid  (b_valid),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_acks(output bit ea, output bit eb);
      ea = 1'b0;
      eb = 1'b0;
      if (reset && m_clear_left == 0) begin
         if (a_req && b_req) begin
            if (a_we || b_we) begin
               if (m_last_b) ea = 1'b1;
               else          eb = 1'b1;
            end else begin
               ea = 1'b1;
               eb = 1'b1;
            end
         end else begin
            ea = a_req;
            eb = b_req;
         end
      end
   endfunction

   function automatic void model_step(input bit ea, input bit eb);
      if (!reset) begin
         m_clear_left = 16;
         m_last_b = 1'b1;
         m_av = 1'b0; m_bv = 1'b0; m_ad = 8'h00; m_bd = 8'h00;
      end else if (m_clear_left > 0) begin
         m_mem[16 - m_clear_left] = 8'h00;
         m_clear_left--;
         m_av = 1'b0; m_bv = 1'b0;
      end else begin
         m_av = ea && !a_we;
         m_bv = eb && !b_we;
         if (m_av) m_ad = m_mem[a_addr];
         if (m_bv) m_bd = m_mem[b_addr];
         if (ea && a_we) m_mem[a_addr] = a_data_i;
         if (eb && b_we) m_mem[b_addr] = b_data_i;
         if (ea && !eb) m_last_b = 1'b0;
         else if (eb && !ea) m_last_b = 1'b1;
      end
   endfunction

   // Called at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic tick(output bit ea, output bit eb, output bit seen_busy);
      #1;
      model_acks(ea, eb);
      seen_busy = (busy === 1'b1);
      check("a_ack", 32'(a_ack), 32'(ea));
      check("b_ack", 32'(b_ack), 32'(eb));
      check("busy", 32'(busy), 32'(!reset || m_clear_left > 0));
      model_step(ea, eb);
      @(posedge clock);
      #1;
      check("a_valid", 32'(a_valid), 32'(m_av));
      check("b_valid", 32'(b_valid), 32'(m_bv));
      check("a_data_o", 32'(a_data_o), 32'(m_ad));
      check("b_data_o", 32'(b_data_o), 32'(m_bd));
   endtask

   task automatic count_busy(input string tag);
      int  n = 0;
      bit  x, y, bz;
      do begin
         tick(x, y, bz);
         if (bz) n++;
      end while (bz && n < 40);
      check(tag, 32'(n), 32'd16);
   endtask

   initial begin
      reset = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = 4'h0; a_data_i = 8'h00;
      b_req = 1'b0; b_we = 1'b0; b_addr = 4'h0; b_data_i = 8'h00;
      @(posedge clock);
      #1;
      tick(ga, gb, bb);
      tick(ga, gb, bb);

      reset = 1'b1;
      count_busy("req033_busy_len");

      a_req = 1'b1; a_we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         a_addr = 4'(i);
         tick(ga, gb, bb);
         check("req033_valid", 32'(a_valid), 32'd1);
         check("req033_zero", 32'(a_data_o), 32'h00);
      end
      a_req = 1'b0;

      b_req = 1'b1; b_we = 1'b0; b_addr = 4'hA;
      tick(ga, gb, bb);
      a_req = 1'b1; a_we = 1'b1; a_addr = 4'hA; a_data_i = 8'hBB;
      tick(ga, gb, bb);
      a_req = 1'b0;
      tick(ga, gb, bb);
      b_req = 1'b0;
      check("req034_b_valid", 32'(b_valid), 32'd1);
      check("req034_b_data", 32'(b_data_o), 32'hBB);

      a_req = 1'b1; a_we = 1'b1; a_addr = 4'h2; a_data_i = 8'hAA;
      tick(ga, gb, bb);
      a_we = 1'b0;
      b_req = 1'b1; b_we = 1'b0; b_addr = 4'hA;
      tick(ga, gb, bb);
      a_req = 1'b0; b_req = 1'b0;
      check("req035_a_data", 32'(a_data_o), 32'hAA);
      check("req035_b_data", 32'(b_data_o), 32'hBB);
      check("req035_valids", 32'({a_valid, b_valid}), 32'h3);

      b_req = 1'b1; b_we = 1'b0; b_addr = 4'h0;
      tick(ga, gb, bb);
      a_req = 1'b1; a_we = 1'b1; a_addr = 4'h5; a_data_i = 8'($urandom);
      b_req = 1'b1; b_we = 1'b1; b_addr = 4'h5; b_data_i = 8'($urandom);
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         tick(ga, gb, bb);
         pat = {pat[4:0], ga};
         if (ga) begin final_d = a_data_i; a_data_i = 8'($urandom); end
         if (gb) begin final_d = b_data_i; b_data_i = 8'($urandom); end
      end
      b_req = 1'b0;
      a_we = 1'b0;
      tick(ga, gb, bb);
      a_req = 1'b0;
      check("req036_order", 32'(pat), 32'h2A);
      check("req036_final", 32'(a_data_o), 32'(final_d));

      reset = 1'b0;
      tick(ga, gb, bb);
      reset = 1'b1;
      repeat (5) tick(ga, gb, bb);
      reset = 1'b0;
      tick(ga, gb, bb);
      reset = 1'b1;
      count_busy("req037_busy_len");
      a_req = 1'b1; a_we = 1'b0; a_addr = 4'h5;
      tick(ga, gb, bb);
      check("req037_cleared", 32'(a_data_o), 32'h00);

      a_we = 1'b1; a_addr = 4'h7; a_data_i = 8'h5C;
      tick(ga, gb, bb);
      a_we = 1'b0;
      tick(ga, gb, bb);
      check("req038_pre", 32'(a_data_o), 32'h5C);
      reset = 1'b0;
      tick(ga, gb, bb);
      a_req = 1'b0;
      reset = 1'b1;
      count_busy("req038_busy_len");
      check("req038_valid", 32'(a_valid), 32'd0);
      check("req038_data", 32'(a_data_o), 32'h00);

      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 149) != 0);
         tick(ga, gb, bb);
         if (!a_req || ga) begin
            a_req    = ($urandom_range(0, 2) != 0);
            a_we     = 1'($urandom_range(0, 1));
            a_addr   = 4'($urandom_range(0, 7));
            a_data_i = 8'($urandom);
         end
         if (!b_req || gb) begin
            b_req    = ($urandom_range(0, 2) != 0);
            b_we     = 1'($urandom_range(0, 1));
            b_addr   = 4'($urandom_range(0, 7));
            b_data_i = 8'($urandom);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ramdp_arbiter.md
RAMDP_ARBITER -- requirements
Module: ramdp_arbiter

Interface
REQ-001 The module SHALL have parameter AddrSize, default 4, which is the RAM address width in bits.
REQ-002 The module SHALL have parameter DataSize, default 8, which is the RAM data width in bits.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous reset, active-low.
REQ-005 The module SHALL have port a_req, input, 1 bit: requester A access request, held high until acked.
REQ-006 The module SHALL have port a_we, input, 1 bit: requester A write (1) or read (0).
REQ-007 The module SHALL have port a_addr, input, AddrSize bits: requester A address.
REQ-008 The module SHALL have port a_data_i, input, DataSize bits: requester A write data.
REQ-009 The module SHALL have port a_ack, output, 1 bit: requester A request accepted this cycle.
REQ-010 The module SHALL have port a_data_o, output, DataSize bits: requester A registered read data.
REQ-011 The module SHALL have port a_valid, output, 1 bit: a_data_o holds new read data this cycle.
REQ-012 The module SHALL have ports b_req, b_we, b_addr, b_data_i, b_ack, b_data_o and b_valid, identical to the requester A ports but for requester B.
REQ-013 The module SHALL have port busy, output, 1 bit: memory clear in progress.

Function
REQ-014 The block SHALL own one RAMDP instance: writes on port 0 at the rising edge when we=1; data_o0/data_o1 are combinational reads of addr0/addr1.
REQ-015 The FSM SHALL have two states: CLEAR (writes 0 to address counter value, counter increments each cycle) and RUN.
REQ-016 CLEAR SHALL last exactly 2^AddrSize cycles covering addresses 0..2^AddrSize-1 in order, then transition to RUN; busy=1 exactly while in CLEAR.
REQ-017 In CLEAR, a_ack and b_ack SHALL be 0 and requester requests SHALL be ignored, not lost: they remain pending because req is held.
REQ-018 In RUN, a conflict SHALL be both requesters requesting with at least one write; on a conflict only the requester not equal to register last SHALL be acked, and last SHALL be set to the winner.
REQ-019 In RUN, when only one requester is requesting, it SHALL be acked immediately via RAM port 0, and last SHALL be set to it.
REQ-020 In RUN, when both requesters request reads, both SHALL be acked in the same cycle: the non-last requester on port 0, the other on port 1; last SHALL be unchanged.
REQ-021 Ack SHALL be combinational from req, we, state and last, and SHALL last one cycle per accepted request; a requester SHALL drop or replace its req after the ack cycle.
REQ-022 An acked write SHALL commit at the rising edge ending its ack cycle.
REQ-023 An acked read SHALL be captured at the rising edge ending its ack cycle; x_data_o and x_valid SHALL update at that edge, and x_valid SHALL be 1 for exactly one cycle.
REQ-024 x_data_o SHALL hold its last value when x_valid=0.
REQ-025 Back-to-back acks to the same requester SHALL be permitted every cycle.
REQ-026 Because writes are serialized against all other accesses, no read-during-write ordering case SHALL exist.

Reset
REQ-027 On a rising edge with reset=0, the block SHALL set state to CLEAR, clear counter to 0, set last to B (so A wins the first conflict), and set a_valid, b_valid, a_data_o and b_data_o to 0.
REQ-028 While reset=0, a_ack, b_ack and the RAM we SHALL be 0, and busy SHALL be 1.
REQ-029 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-030 Reset asserted mid-RUN SHALL abort any pending valid, and SHALL cause no ack until a full clear completes.

Structure
REQ-031 A shared package ramdp_pkg SHALL hold the FSM state encoding (CLEAR, RUN) and the requester ID encoding (REQ_A, REQ_B).
REQ-032 The single sub-module SHALL be the existing RAMDP, instantiated as ramdp; the arbitration, FSM and output registers SHALL be local.

Verification (AddrSize=4, DataSize=8)
REQ-033 Release reset -> busy=1 for exactly 16 cycles; then A reads of 0x0..0xF each return 0x00 with a_valid one cycle after a_ack.
REQ-034 Same cycle: A writes 0xA<-0xBB and B reads 0xA -> a_ack first; b_ack next cycle; b_data_o=0xBB with b_valid the cycle after b_ack.
REQ-035 Simultaneous reads A@0x2 and B@0xA after writes 0x2<-0xAA and 0xA<-0xBB -> both acks in one cycle; next cycle a_data_o=0xAA, b_data_o=0xBB, both valid.
REQ-036 Both requesters hold write requests for 6 cycles -> acks alternate A,B,A,B,A,B; final memory contents match the last acked data.
REQ-037 Reset pulsed low during CLEAR at counter=5 -> busy stays high and clear restarts at 0, with busy=1 for 16 cycles after release.
REQ-038 Reset pulsed low in the ack cycle of an A read -> a_valid never rises and a_data_o=0x00.
